// File: rtl/residual_tx_packer.sv
// residual_tx_packer: serializes 4x4 residual blocks into header + data bytes
// for the TX FIFO, appending a trailer byte after the last block of a frame.
module residual_tx_packer #(
   parameter int         BYTES_PER_BLK    = 16,
   parameter int         BLOCKS_PER_FRAME = 4096,
   parameter logic [7:0] TRAILER_BYTE     = 8'hA5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [8*BYTES_PER_BLK-1:0] residual_flat,
   input  logic [1:0]                 mode,
   input  logic                       residual_ready,
   input  logic                       frame_start,
   output logic                       DCT_busy,
   input  logic                       FIFO_tx_full,
   output logic [7:0]                 FIFO_tx_din,
   output logic                       FIFO_tx_wr_en,
   output logic                       frame_sent,
   output logic                       overflow
);
   localparam int BW = $clog2(BYTES_PER_BLK);
   localparam int CW = $clog2(BLOCKS_PER_FRAME) + 1;
   typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_t;
   state_t                     state;
   logic [8*BYTES_PER_BLK-1:0] hold_data;
   logic [1:0]                 hold_mode;
   logic [BW-1:0]              byte_cnt;
   logic [CW-1:0]              blk_cnt;
   logic [CW-1:0]              blk_nxt;
   logic [7:0]                 cur_byte;
   logic                       wr;
   assign wr            = (state != IDLE) && !FIFO_tx_full;
   assign FIFO_tx_wr_en = wr;
   assign DCT_busy      = state != IDLE;
   assign cur_byte      = hold_data[{byte_cnt, 3'b000} +: 8];
   assign blk_nxt       = blk_cnt + CW'(1);
   // header carries the block sequence number modulo 64
   always_comb
      FIFO_tx_din = state == HDR  ? {hold_mode, 6'(blk_cnt)} :
                    state == DATA ? cur_byte :
                    state == TRL  ? TRAILER_BYTE : 8'h00;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         hold_data  <= '0;
         hold_mode  <= '0;
         byte_cnt   <= '0;
         blk_cnt    <= '0;
         frame_sent <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         frame_sent <= 1'b0;
         if (residual_ready && state != IDLE) overflow <= 1'b1;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  blk_cnt  <= '0;
                  overflow <= 1'b0;
               end
               if (residual_ready) begin
                  hold_data <= residual_flat;
                  hold_mode <= mode;
                  state     <= HDR;
               end
            end
            HDR: if (wr) begin
               state    <= DATA;
               byte_cnt <= '0;
            end
            DATA: if (wr) begin
               byte_cnt <= byte_cnt + BW'(1);
               if (byte_cnt == BW'(BYTES_PER_BLK - 1)) begin
                  blk_cnt <= blk_nxt;
                  state   <= blk_nxt == CW'(BLOCKS_PER_FRAME) ? TRL : IDLE;
               end
            end
            TRL: if (wr) begin
               state      <= IDLE;
               blk_cnt    <= '0;
               frame_sent <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_residual_tx_packer.sv
// tb_residual_tx_packer: directed and random stimulus against a byte-queue
// model of the packer; the model is checked every cycle on the falling edge.
module tb_residual_tx_packer;
   localparam int NBLK = 4;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] residual_flat = '0;
   logic [1:0]   mode = '0;
   logic         residual_ready = 1'b0;
   logic         frame_start = 1'b0;
   logic         DCT_busy;
   logic         FIFO_tx_full = 1'b0;
   logic [7:0]   FIFO_tx_din;
   logic         FIFO_tx_wr_en;
   logic         frame_sent;
   logic         overflow;
   int total = 0;
   int bad = 0;
   logic [8:0] q[$];
   logic [7:0] wlog[$];
   int  m_blk = 0;
   bit  m_ovf = 0;
   bit  m_fs = 0;
   int  fs_cnt = 0;
   localparam logic [127:0] PAT = 128'h0F0E0D0C0B0A09080706050403020100;

   residual_tx_packer #(.BLOCKS_PER_FRAME(NBLK)) dut (
      .clk(clk), .rst_n(rst_n), .residual_flat(residual_flat), .mode(mode),
      .residual_ready(residual_ready), .frame_start(frame_start), .DCT_busy(DCT_busy),
      .FIFO_tx_full(FIFO_tx_full), .FIFO_tx_din(FIFO_tx_din), .FIFO_tx_wr_en(FIFO_tx_wr_en),
      .frame_sent(frame_sent), .overflow(overflow));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an accepted block becomes 17 expected bytes (plus trailer at frame end)
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_busy", DCT_busy, 0);
         check("rst_wr", FIFO_tx_wr_en, 0);
         check("rst_din", FIFO_tx_din, 0);
         check("rst_ovf", overflow, 0);
         check("rst_fs", frame_sent, 0);
         q.delete();
         m_blk = 0;
         m_ovf = 0;
         m_fs = 0;
      end else begin
         automatic bit busy = q.size() > 0;
         check("busy", DCT_busy, busy);
         check("wr_en", FIFO_tx_wr_en, busy && !FIFO_tx_full);
         check("overflow", overflow, m_ovf);
         check("frame_sent", frame_sent, m_fs);
         if (frame_sent) fs_cnt++;
         m_fs = 0;
         if (FIFO_tx_wr_en) wlog.push_back(FIFO_tx_din);
         if (busy && !FIFO_tx_full) begin
            check("din", FIFO_tx_din, q[0][7:0]);
            m_fs = q[0][8];
            void'(q.pop_front());
         end
         if (!busy) begin
            if (frame_start) begin
               m_blk = 0;
               m_ovf = 0;
            end
            if (residual_ready) begin
               q.push_back({1'b0, mode, 6'(m_blk)});
               for (int i = 0; i < 16; i++) q.push_back({1'b0, residual_flat[8*i +: 8]});
               m_blk++;
               if (m_blk == NBLK) begin
                  q.push_back({1'b1, 8'hA5});
                  m_blk = 0;
               end
            end
         end else if (residual_ready) m_ovf = 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [127:0] d, input logic [1:0] m, input bit rr, input bit fs);
      residual_flat = d;
      mode = m;
      residual_ready = rr;
      frame_start = fs;
      step();
      residual_ready = 0;
      frame_start = 0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (DCT_busy && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) check("idle_timeout", 1, 0);
   endtask

   initial begin
      int n;
      int f0;
      step();
      step();
      rst_n = 1;
      step();
      // 1: single block, no stalls
      wlog.delete();
      pulse(PAT, 2'd2, 1, 0);
      wait_idle(n);
      check("t1_latency", n, 17);
      check("t1_count", wlog.size(), 17);
      check("t1_hdr", wlog[0], 8'h80);
      check("t1_b0", wlog[1], 8'h00);
      check("t1_b15", wlog[16], 8'h0F);
      // 2: five-cycle stall while byte 3 is pending
      wlog.delete();
      pulse(PAT, 2'd2, 1, 0);
      n = 0;
      while (DCT_busy && n < 300) begin
         if (n == 4) FIFO_tx_full = 1;
         if (n == 9) FIFO_tx_full = 0;
         step();
         n++;
      end
      check("t2_latency", n, 22);
      check("t2_count", wlog.size(), 17);
      check("t2_hdr", wlog[0], 8'h81);
      check("t2_b3", wlog[4], 8'h03);
      check("t2_b4", wlog[5], 8'h04);
      // 3: overflow on strobe while busy, cleared by frame_start in IDLE
      pulse(PAT, 2'd1, 1, 0);
      repeat (5) step();
      pulse(~PAT, 2'd3, 1, 0);
      check("t3_ovf_set", overflow, 1);
      wait_idle(n);
      check("t3_ovf_sticky", overflow, 1);
      pulse('0, 2'd0, 0, 1);
      check("t3_ovf_clr", overflow, 0);
      // 4: full frame, trailer, frame_sent, wrap to seq 0
      wlog.delete();
      f0 = fs_cnt;
      for (int b = 0; b < NBLK; b++) begin
         pulse({4{$urandom}}, 2'd1, 1, 0);
         wait_idle(n);
      end
      step();
      check("t4_count", wlog.size(), 17 * NBLK + 1);
      check("t4_hdr0", wlog[0], 8'h40);
      check("t4_hdr1", wlog[17], 8'h41);
      check("t4_hdr3", wlog[51], 8'h43);
      check("t4_trl", wlog[68], 8'hA5);
      check("t4_fs_pulses", fs_cnt - f0, 1);
      pulse(PAT, 2'd1, 1, 0);
      wait_idle(n);
      check("t4_wrap_hdr", wlog[69], 8'h40);
      // 5: reset mid-data aborts the block
      pulse(PAT, 2'd3, 1, 0);
      repeat (8) step();
      rst_n = 0;
      #1;
      check("t5_busy", DCT_busy, 0);
      check("t5_wr", FIFO_tx_wr_en, 0);
      check("t5_din", FIFO_tx_din, 0);
      step();
      rst_n = 1;
      step();
      wlog.delete();
      pulse(PAT, 2'd3, 1, 0);
      wait_idle(n);
      check("t5_hdr", wlog[0], 8'hC0);
      // 6: frame_start with residual_ready in the same IDLE cycle
      pulse(PAT, 2'd2, 1, 0);
      wait_idle(n);
      wlog.delete();
      pulse(PAT, 2'd2, 1, 1);
      wait_idle(n);
      check("t6_hdr", wlog[0], 8'h80);
      // random traffic
      for (int c = 0; c < 4000; c++) begin
         FIFO_tx_full = ($urandom % 4) == 0;
         residual_flat = {$urandom, $urandom, $urandom, $urandom};
         mode = 2'($urandom);
         residual_ready = ($urandom % 6) == 0;
         frame_start = ($urandom % 20) == 0;
         step();
      end
      residual_ready = 0;
      frame_start = 0;
      FIFO_tx_full = 0;
      wait_idle(n);
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
